// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad event encoder.
//   - Event type codes carried in o_Event_Data[3:2]
//   - Event/key widths and key count
//   - Typematic repeat FSM state enum
package keypad_pkg;

  localparam int unsigned EVT_W    = 4;
  localparam int unsigned KEY_W    = 2;
  localparam int unsigned NUM_KEYS = 4;

  localparam logic [1:0] EVT_RELEASE = 2'b00;
  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_REPEAT  = 2'b10;

  typedef enum logic [1:0] {
    REP_IDLE,
    REP_DELAY,
    REP_REPEAT
  } rep_state_e;

endpackage

// File: rtl/keypad_sync_fifo.sv
// Small synchronous show-ahead FIFO for key events.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full unless popping)
//   pop        : remove head entry (ignored when empty)
//   pop_data   : head entry, forced to zero while empty
//   full/empty : occupancy flags
//   count      : number of stored entries
// A push into an empty FIFO becomes visible on the following cycle.
module keypad_sync_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pop_data is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/keypad_event_encoder.sv
// Converts debounced key levels into press / release / typematic repeat
// events, queued in a small FIFO behind a valid/ready interface.
//   i_Clk, i_Rst_n : clock, asynchronous active-low reset
//   i_Switch       : debounced key levels, 1 = pressed
//   o_Event_Valid  : FIFO head holds an event
//   i_Event_Ready  : consumer accepts head event
//   o_Event_Data   : [3:2] type, [1:0] key index
//   o_Held         : registered copy of i_Switch
//   o_Overflow     : sticky, a repeat event was dropped
//   i_Ovf_Clr      : synchronous clear of o_Overflow (set wins)
module keypad_event_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 2500000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic [3:0] i_Switch,
  output logic       o_Event_Valid,
  input  logic       i_Event_Ready,
  output logic [3:0] o_Event_Data,
  output logic [3:0] o_Held,
  output logic       o_Overflow,
  input  logic       i_Ovf_Clr
);

  localparam int unsigned CNT_N = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CNT_W = ($clog2(CNT_N) < 1) ? 1 : $clog2(CNT_N);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  logic [NUM_KEYS-1:0] held_q;
  logic [NUM_KEYS-1:0] press_pend_q, press_pend_d;
  logic [NUM_KEYS-1:0] rel_pend_q, rel_pend_d;
  logic                rep_pend_q, rep_pend_d;
  rep_state_e          state_q, state_d;
  logic [KEY_W-1:0]    rep_key_q, rep_key_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                ovf_q, ovf_d;

  logic [NUM_KEYS-1:0] rise, fall;
  logic                push, rep_taken, tick, ovf_set, ev_pop, can_push;
  logic [EVT_W-1:0]    push_data;
  logic [KEY_W-1:0]    new_key;
  logic                fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign ev_pop        = i_Event_Ready && (fifo_count != '0);
  assign can_push      = ~fifo_full | ev_pop;
  assign o_Event_Valid = ~fifo_empty;
  assign o_Held        = held_q;
  assign o_Overflow    = ovf_q;

  // Edge detect and enqueue arbiter. The arbiter consumes the current
  // pend bits first; new edges are then merged, so an edge opposite to an
  // event written this same cycle is kept rather than cancelled.
  always_comb begin
    rise         = i_Switch & ~held_q;
    fall         = held_q & ~i_Switch;
    push         = 1'b0;
    push_data    = '0;
    rep_taken    = 1'b0;
    press_pend_d = press_pend_q;
    rel_pend_d   = rel_pend_q;
    if (can_push) begin
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        if (!push && rel_pend_q[k]) begin
          push          = 1'b1;
          push_data     = {EVT_RELEASE, KEY_W'(k)};
          rel_pend_d[k] = 1'b0;
        end
      end
      for (int unsigned k = 0; k < NUM_KEYS; k++) begin
        if (!push && press_pend_q[k]) begin
          push            = 1'b1;
          push_data       = {EVT_PRESS, KEY_W'(k)};
          press_pend_d[k] = 1'b0;
        end
      end
      if (!push && rep_pend_q) begin
        push      = 1'b1;
        push_data = {EVT_REPEAT, rep_key_q};
        rep_taken = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (rise[k]) begin
        if (rel_pend_d[k]) rel_pend_d[k]   = 1'b0;
        else               press_pend_d[k] = 1'b1;
      end
      if (fall[k]) begin
        if (press_pend_d[k]) press_pend_d[k] = 1'b0;
        else                 rel_pend_d[k]   = 1'b1;
      end
    end
  end

  // Repeat FSM. A new press overrides everything, including a release of
  // the old repeat key and any tick due this cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rep_key_d  = rep_key_q;
    tick       = 1'b0;
    ovf_set    = 1'b0;
    new_key    = '0;
    rep_pend_d = rep_pend_q & ~rep_taken;
    cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      REP_DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          tick    = 1'b1;
          cnt_d   = '0;
          state_d = REP_REPEAT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REP_REPEAT: begin
        if (cnt_q == RATE_LAST) begin
          tick  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: ;
    endcase
    if (state_q != REP_IDLE && fall[rep_key_q]) begin
      state_d    = REP_IDLE;
      cnt_d      = '0;
      tick       = 1'b0;
      rep_pend_d = 1'b0;
    end
    for (int unsigned k = 0; k < NUM_KEYS; k++) begin
      if (rise[k]) new_key = KEY_W'(k);
    end
    if (|rise) begin
      state_d   = REP_DELAY;
      cnt_d     = '0;
      rep_key_d = new_key;
      tick      = 1'b0;
    end
    if (tick) begin
      if (rep_pend_d) ovf_set    = 1'b1;
      else            rep_pend_d = 1'b1;
    end
    ovf_d = ovf_set | (ovf_q & ~i_Ovf_Clr);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      held_q       <= '0;
      press_pend_q <= '0;
      rel_pend_q   <= '0;
      rep_pend_q   <= 1'b0;
      state_q      <= REP_IDLE;
      rep_key_q    <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      held_q       <= i_Switch;
      press_pend_q <= press_pend_d;
      rel_pend_q   <= rel_pend_d;
      rep_pend_q   <= rep_pend_d;
      state_q      <= state_d;
      rep_key_q    <= rep_key_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  keypad_sync_fifo #(
    .WIDTH(EVT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (i_Clk),
    .rst_n    (i_Rst_n),
    .push     (push),
    .push_data(push_data),
    .pop      (ev_pop),
    .pop_data (o_Event_Data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Bench for keypad_event_encoder: directed scenarios followed by random key
// activity, all checked every cycle against an event-level reference model.
module tb_keypad_event_encoder;

  localparam int unsigned RD = 20;
  localparam int unsigned RR = 5;
  localparam int unsigned FD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = '0;
  logic       rdy = 1'b0;
  logic       clr = 1'b0;
  logic       o_Event_Valid;
  logic [3:0] o_Event_Data;
  logic [3:0] o_Held;
  logic       o_Overflow;

  keypad_event_encoder #(
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .FIFO_DEPTH  (FD)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_n      (rst_n),
    .i_Switch     (sw),
    .o_Event_Valid(o_Event_Valid),
    .i_Event_Ready(rdy),
    .o_Event_Data (o_Event_Data),
    .o_Held       (o_Held),
    .o_Overflow   (o_Overflow),
    .i_Ovf_Clr    (clr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int bad_rep = 0;

  // Reference model: queue of events, per-key outstanding press/release,
  // one outstanding repeat, and elapsed time since the latest press.
  logic [3:0] m_q[$];
  bit   [3:0] m_held, m_pp, m_rp;
  bit         m_rep, m_act, m_ovf;
  int         m_key, m_el;

  task automatic model_reset();
    m_q.delete();
    m_held = '0; m_pp = '0; m_rp = '0;
    m_rep = 0; m_act = 0; m_ovf = 0; m_key = 0; m_el = 0;
  endtask

  task automatic model_edge();
    bit done, tick, set_ovf, any_rise;
    logic [3:0] ev;
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    done = 0;
    ev = '0;
    if (m_q.size() < FD) begin
      for (int k = 0; k < 4; k++)
        if (!done && m_rp[k]) begin ev = 4'(k); m_rp[k] = 0; done = 1; end
      for (int k = 0; k < 4; k++)
        if (!done && m_pp[k]) begin ev = 4'(4 + k); m_pp[k] = 0; done = 1; end
      if (!done && m_rep) begin ev = 4'(8 + m_key); m_rep = 0; done = 1; end
      if (done) m_q.push_back(ev);
    end
    tick = 0;
    if (m_act) begin
      m_el++;
      tick = (m_el >= RD) && (((m_el - RD) % RR) == 0);
    end
    any_rise = 0;
    for (int k = 0; k < 4; k++) begin
      if (sw[k] && !m_held[k]) begin
        if (m_rp[k]) m_rp[k] = 0; else m_pp[k] = 1;
      end
      if (!sw[k] && m_held[k]) begin
        if (m_pp[k]) m_pp[k] = 0; else m_rp[k] = 1;
      end
    end
    if (m_act && !sw[m_key] && m_held[m_key]) begin
      m_act = 0; m_rep = 0; tick = 0;
    end
    for (int k = 0; k < 4; k++)
      if (sw[k] && !m_held[k]) begin any_rise = 1; m_key = k; end
    if (any_rise) begin m_act = 1; m_el = 0; tick = 0; end
    set_ovf = 0;
    if (tick) begin
      if (m_rep) set_ovf = 1; else m_rep = 1;
    end
    m_ovf = set_ovf | (m_ovf & !clr);
    m_held = sw;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid", 32'(o_Event_Valid), 32'(m_q.size() != 0));
    chk("data", 32'(o_Event_Data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    chk("held", 32'(o_Held), 32'(m_held));
    chk("ovf", 32'(o_Overflow), 32'(m_ovf));
  endtask

  task automatic step();
    bit pv;
    logic [3:0] pd;
    pv = o_Event_Valid && rdy;
    pd = o_Event_Data;
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    #1;
    check_all();
    if (pv && pd[3:2] == 2'b10 && pd[1:0] != 2'd2) bad_rep++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    steps(3);
    chk("rst_valid", 32'(o_Event_Valid), 32'd0);
    chk("rst_data", 32'(o_Event_Data), 32'd0);
    chk("rst_ovf", 32'(o_Overflow), 32'd0);
    rst_n = 1'b1;
    rdy   = 1'b1;
    steps(2);

    // Single press / release of key 1
    sw = 4'b0010;
    step();
    chk("p1_lat1_valid", 32'(o_Event_Valid), 32'd0);
    step();
    chk("p1_valid", 32'(o_Event_Valid), 32'd1);
    chk("p1_data", 32'(o_Event_Data), 32'h5);
    steps(5);
    sw = 4'b0000;
    steps(2);
    chk("r1_data", 32'(o_Event_Data), 32'h1);
    steps(3);

    // Hold key 3 long enough for several repeats
    sw = 4'b1000;
    steps(40);
    sw = 4'b0000;
    steps(5);

    // All keys at once
    sw = 4'b1111;
    steps(2);
    chk("all_p0", 32'(o_Event_Data), 32'h4);
    step(); chk("all_p1", 32'(o_Event_Data), 32'h5);
    step(); chk("all_p2", 32'(o_Event_Data), 32'h6);
    step(); chk("all_p3", 32'(o_Event_Data), 32'h7);
    step(); chk("all_p_done", 32'(o_Event_Valid), 32'd0);
    steps(4);
    sw = 4'b0000;
    steps(2);
    chk("all_r0", 32'(o_Event_Data), 32'h0);
    step(); chk("all_r1", 32'(o_Event_Data), 32'h1);
    step(); chk("all_r2", 32'(o_Event_Data), 32'h2);
    step(); chk("all_r3", 32'(o_Event_Data), 32'h3);
    steps(3);

    // Backpressure with overflow
    rdy = 1'b0;
    sw  = 4'b0001;
    steps(60);
    chk("bp_valid", 32'(o_Event_Valid), 32'd1);
    chk("bp_data", 32'(o_Event_Data), 32'h4);
    chk("bp_ovf", 32'(o_Overflow), 32'd1);
    rdy = 1'b1;
    steps(10);
    sw = 4'b0000;
    steps(10);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ovf_clr", 32'(o_Overflow), 32'd0);

    // Repeat handover from key 1 to key 2
    bad_rep = 0;
    sw = 4'b0010;
    steps(10);
    sw = 4'b0110;
    steps(30);
    sw = 4'b0100;
    steps(15);
    sw = 4'b0000;
    steps(10);
    chk("handover_other_key_reps", 32'(bad_rep), 32'd0);

    // Reset mid-stream with events queued and keys held
    rdy = 1'b0;
    sw  = 4'b1011;
    steps(5);
    chk("pre_rst_valid", 32'(o_Event_Valid), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_valid", 32'(o_Event_Valid), 32'd0);
    model_reset();
    steps(2);
    rst_n = 1'b1;
    rdy   = 1'b1;
    step();
    chk("post_rst_lat1", 32'(o_Event_Valid), 32'd0);
    step();
    chk("post_rst_valid", 32'(o_Event_Valid), 32'd1);
    chk("post_rst_data", 32'(o_Event_Data), 32'h4);
    steps(5);
    sw = 4'b0000;
    steps(5);

    // Random key activity, ready and overflow clear
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(11) == 0) sw = sw ^ (4'b0001 << $urandom_range(3));
      rdy = ($urandom_range(3) != 0);
      clr = ($urandom_range(19) == 0);
      step();
    end
    sw  = 4'b0000;
    rdy = 1'b1;
    clr = 1'b0;
    steps(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
